// File: rtl/limn2600_alu_issue_if.sv
// Decoded-instruction handshake into the Limn2600 ALU issue stage.
// A transfer occurs on a rising clk edge where in_valid && in_ready; in_ready never looks at in_valid.
interface limn2600_alu_issue_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [AW-1:0]   in_rd;
    logic [AW-1:0]   in_ra;
    logic [AW-1:0]   in_rb;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;

    modport master (
        output in_valid, in_op, in_rd, in_ra, in_rb, in_imm, in_use_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm, in_use_imm,
        output in_ready
    );
endinterface

// File: rtl/limn2600_alu_issue.sv
// Operand fetch / issue / writeback around the 1-cycle registered Limn2600 ALU.
// Distance-1 RAW hazards stall one cycle; distance-2 hazards bypass from alu_c.
module limn2600_alu_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    limn2600_alu_issue_if.slave      in_if,
    output logic [2:0]               alu_op,
    output logic [XLEN-1:0]          alu_a,
    output logic [XLEN-1:0]          alu_b,
    input  logic [XLEN-1:0]          alu_c,
    output logic                     wb_valid,
    output logic [$clog2(NREG)-1:0]  wb_rd,
    output logic [XLEN-1:0]          wb_data,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [XLEN-1:0]          dbg_data
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic            iss_valid;
    logic [2:0]      iss_op;
    logic [AW-1:0]   iss_rd;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [AW-1:0]   src_b;

    // Only the instruction currently in issue can be a distance-1 producer.
    always_comb begin
        hazard = iss_valid && (iss_op != 3'b000) && (iss_rd != '0) &&
                 ((iss_rd == in_if.in_ra) || (!in_if.in_use_imm && (iss_rd == in_if.in_rb)));
        in_if.in_ready = !hazard;
        accept = in_if.in_valid && !hazard;
    end

    // wb_valid already excludes NOPs; src != 0 excludes rd=0 forwarding.
    always_comb begin
        src_b = in_if.in_rb;
        if (in_if.in_ra == '0)
            opa = '0;
        else if (wb_valid && (wb_rd == in_if.in_ra))
            opa = alu_c;
        else
            opa = regs[in_if.in_ra];

        if (in_if.in_use_imm)
            opb = in_if.in_imm;
        else if (src_b == '0)
            opb = '0;
        else if (wb_valid && (wb_rd == src_b))
            opb = alu_c;
        else
            opb = regs[src_b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_op    <= 3'b000;
            iss_rd    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (wb_valid && (wb_rd != '0))
                regs[wb_rd] <= alu_c;
            wb_valid <= iss_valid && (iss_op != 3'b000);
            wb_rd    <= iss_rd;
            if (accept) begin
                iss_valid <= 1'b1;
                iss_op    <= in_if.in_op;
                iss_rd    <= in_if.in_rd;
                alu_a     <= opa;
                alu_b     <= opb;
            end else begin
                // Empty issue slot presents NOP so the ALU holds c; a/b keep their values.
                iss_valid <= 1'b0;
                iss_op    <= 3'b000;
            end
        end
    end

    assign alu_op  = iss_op;
    assign wb_data = alu_c;

    always_comb begin
        if (dbg_addr == '0)
            dbg_data = '0;
        else
            dbg_data = regs[dbg_addr];
    end
endmodule

// File: tb/tb_limn2600_alu_issue.sv
// Directed bench for limn2600_alu_issue with a behavioural registered ALU attached.
module tb_limn2600_alu_issue;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    logic            clk;
    logic            rst;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_c;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    int n_checks;
    int n_fail;

    limn2600_alu_issue_if #(.XLEN(XLEN), .NREG(NREG)) in_if ();

    limn2600_alu_issue #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_if),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_c    (alu_c),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: c valid the cycle after op/a/b, holds on op 000.
    always @(posedge clk) begin
        if (rst)
            alu_c <= '0;
        else begin
            case (alu_op)
                3'b111: alu_c <= alu_a + alu_b;
                3'b110: alu_c <= alu_a - alu_b;
                3'b011: alu_c <= alu_a & alu_b;
                3'b010: alu_c <= alu_a ^ alu_b;
                3'b001: alu_c <= alu_a | alu_b;
                3'b101: alu_c <= {31'b0, alu_a < alu_b};
                3'b100: alu_c <= {31'b0, $signed(alu_a) < $signed(alu_b)};
                default: alu_c <= alu_c;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic [XLEN-1:0] imm, input logic use_imm);
        in_if.in_valid   = 1'b1;
        in_if.in_op      = op;
        in_if.in_rd      = rd;
        in_if.in_ra      = ra;
        in_if.in_rb      = rb;
        in_if.in_imm     = imm;
        in_if.in_use_imm = use_imm;
        #1;
    endtask

    task automatic idle();
        in_if.in_valid   = 1'b0;
        in_if.in_op      = 3'b000;
        in_if.in_rd      = '0;
        in_if.in_ra      = '0;
        in_if.in_rb      = '0;
        in_if.in_imm     = '0;
        in_if.in_use_imm = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] r, input logic [XLEN-1:0] exp);
        dbg_addr = r;
        #1;
        check_eq(tag, {32'b0, dbg_data}, {32'b0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        dbg_addr = '0;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;

        // reset state
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = i[AW-1:0];
            #1;
            check_eq($sformatf("reset_r%0d", i), {32'b0, dbg_data}, 64'd0);
        end
        check_eq("reset_ready", {63'b0, in_if.in_ready}, 64'd1);
        check_eq("reset_op", {61'b0, alu_op}, 64'd0);
        check_eq("reset_wbv", {63'b0, wb_valid}, 64'd0);

        // single ADD r1 = r0 + 5
        drive(3'b111, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        check_eq("add_ready", {63'b0, in_if.in_ready}, 64'd1);
        step();
        idle();
        check_eq("add_op", {61'b0, alu_op}, 64'h7);
        check_eq("add_a", {32'b0, alu_a}, 64'd0);
        check_eq("add_b", {32'b0, alu_b}, 64'd5);
        step();
        check_eq("add_wbv", {63'b0, wb_valid}, 64'd1);
        check_eq("add_wbrd", {59'b0, wb_rd}, 64'd1);
        check_eq("add_wbdata", {32'b0, wb_data}, 64'd5);
        check_eq("add_op_idle", {61'b0, alu_op}, 64'd0);
        step();
        check_reg("add_r1", 5'd1, 32'd5);

        // distance-1 hazard: ADD r1=r0+7, SUB r2=r1-2
        drive(3'b111, 5'd1, 5'd0, 5'd0, 32'd7, 1'b1);
        step();
        drive(3'b110, 5'd2, 5'd1, 5'd0, 32'd2, 1'b1);
        check_eq("haz_stall", {63'b0, in_if.in_ready}, 64'd0);
        step();
        check_eq("haz_release", {63'b0, in_if.in_ready}, 64'd1);
        check_eq("haz_stall_op", {61'b0, alu_op}, 64'd0);
        step();
        idle();
        check_eq("haz_op", {61'b0, alu_op}, 64'h6);
        check_eq("haz_fwd_a", {32'b0, alu_a}, 64'd7);
        check_eq("haz_b", {32'b0, alu_b}, 64'd2);
        step();
        step();
        check_reg("haz_r2", 5'd2, 32'd5);
        check_reg("haz_r1", 5'd1, 32'd7);

        // distance-2 bypass: ADD r3=-1, OR r7=r0|1, SLTS r4=r3<r0
        drive(3'b111, 5'd3, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        step();
        drive(3'b001, 5'd7, 5'd0, 5'd0, 32'd1, 1'b1);
        check_eq("byp_or_ready", {63'b0, in_if.in_ready}, 64'd1);
        step();
        drive(3'b100, 5'd4, 5'd3, 5'd0, 32'd0, 1'b0);
        check_eq("byp_slts_ready", {63'b0, in_if.in_ready}, 64'd1);
        step();
        idle();
        check_eq("byp_op", {61'b0, alu_op}, 64'h4);
        check_eq("byp_fwd_a", {32'b0, alu_a}, 64'hFFFF_FFFF);
        check_eq("byp_b", {32'b0, alu_b}, 64'd0);
        step();
        step();
        check_reg("slts_r4", 5'd4, 32'd1);
        check_reg("or_r7", 5'd7, 32'd1);
        drive(3'b101, 5'd4, 5'd3, 5'd0, 32'd0, 1'b0);
        step();
        idle();
        step();
        step();
        check_reg("slt_r4", 5'd4, 32'd0);

        // r0 destination and NOP
        drive(3'b111, 5'd0, 5'd0, 5'd0, 32'd9, 1'b1);
        step();
        drive(3'b000, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
        check_eq("nop_ready", {63'b0, in_if.in_ready}, 64'd1);
        step();
        idle();
        check_eq("r0_wbv", {63'b0, wb_valid}, 64'd1);
        check_eq("r0_wbrd", {59'b0, wb_rd}, 64'd0);
        check_eq("r0_wbdata", {32'b0, wb_data}, 64'd9);
        check_eq("nop_a_no_fwd", {32'b0, alu_a}, 64'd0);
        check_eq("nop_op", {61'b0, alu_op}, 64'd0);
        drive(3'b111, 5'd8, 5'd0, 5'd0, 32'd0, 1'b0);
        check_eq("r0_read_ready", {63'b0, in_if.in_ready}, 64'd1);
        step();
        idle();
        check_eq("nop_wbv", {63'b0, wb_valid}, 64'd0);
        check_eq("r0_read_a", {32'b0, alu_a}, 64'd0);
        step();
        step();
        check_reg("r0_stays", 5'd0, 32'd0);
        check_reg("r5_unchanged", 5'd5, 32'd0);

        // reset mid-flight
        drive(3'b111, 5'd6, 5'd0, 5'd0, 32'd3, 1'b1);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_wbv", {63'b0, wb_valid}, 64'd0);
        check_eq("rst_op", {61'b0, alu_op}, 64'd0);
        check_eq("rst_a", {32'b0, alu_a}, 64'd0);
        check_eq("rst_ready", {63'b0, in_if.in_ready}, 64'd1);
        step();
        check_reg("rst_r6", 5'd6, 32'd0);
        check_reg("rst_r1", 5'd1, 32'd0);
        check_eq("rst_wbv2", {63'b0, wb_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
